// File: rtl/core_pkg.sv
// Shared types for the decode/execute boundary: the control and data words
// carried by the ID/EX pipeline register, and the bubble constant.
package core_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int REG_ADDR_W = 5;

    // Control word produced by the main decoder and the ALU decoder.
    typedef struct packed {
        logic [2:0] result_src;
        logic [4:0] alu_control;
        logic [2:0] func3;
        logic [1:0] forward_src;
        logic [3:0] cause;
        logic       mem_we;
        logic       reg_we;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       pc_target_src;
        logic       mem_access;
        logic       ecall_instr;
        logic       load_instr;
    } t_ex_ctrl;

    // Operand and address word handed to the execute stage.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [DATA_WIDTH-1:0] imm_ext;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
    } t_ex_data;

    // An all-zero control word has no architectural side effects.
    localparam t_ex_ctrl EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register: async reset, synchronous clear, load enable.
// Clear takes priority over enable so a flush always wins over a stall.
module pipe_reg_en_clr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Register update: reset, then clear, then enabled load, else hold.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/preg_decode_execute.sv
// ID/EX pipeline register with stall, flush, valid tracking, a load-use
// tap for the hazard unit and a saturating bubble counter.
module preg_decode_execute
    import core_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_stall_exec,
    input  logic                  i_flush_exec,
    input  logic                  i_valid,
    input  t_ex_ctrl              i_ctrl,
    input  t_ex_data              i_data,
    output t_ex_ctrl              o_ctrl,
    output t_ex_data              o_data,
    output logic                  o_valid,
    output logic [REG_ADDR_W-1:0] o_load_rd,
    output logic [CNT_WIDTH-1:0]  o_bubble_cnt
);

    logic                 load_en;
    logic                 bubble_write;
    t_ex_ctrl             ctrl_next;
    logic [CNT_WIDTH-1:0] bubble_cnt_reg;

    assign load_en = ~i_stall_exec;

    // An invalid decode slot must never carry side-effecting controls forward.
    assign ctrl_next = i_valid ? i_ctrl : EX_CTRL_BUBBLE;

    // An edge writes a bubble when flushing, or loading an invalid slot.
    assign bubble_write = i_flush_exec | (~i_stall_exec & ~i_valid);

    pipe_reg_en_clr #(.WIDTH($bits(t_ex_ctrl))) u_ctrl_reg (
        .clk  (i_clk),
        .arst (i_arst),
        .en   (load_en),
        .clr  (i_flush_exec),
        .d    (ctrl_next),
        .q    (o_ctrl)
    );

    pipe_reg_en_clr #(.WIDTH($bits(t_ex_data))) u_data_reg (
        .clk  (i_clk),
        .arst (i_arst),
        .en   (load_en),
        .clr  (i_flush_exec),
        .d    (i_data),
        .q    (o_data)
    );

    pipe_reg_en_clr #(.WIDTH(1)) u_valid_reg (
        .clk  (i_clk),
        .arst (i_arst),
        .en   (load_en),
        .clr  (i_flush_exec),
        .d    (i_valid),
        .q    (o_valid)
    );

    // Bubble counter: count every bubble write, stick at all-ones.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            bubble_cnt_reg <= '0;
        end else if (bubble_write && (bubble_cnt_reg != '1)) begin
            bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
        end
    end

    assign o_bubble_cnt = bubble_cnt_reg;

    // Load-use tap: expose rd only for a live load that writes a real register.
    always_comb begin
        o_load_rd = '0;
        if (o_valid && o_ctrl.load_instr && (o_data.rd_addr != '0)) begin
            o_load_rd = o_data.rd_addr;
        end
    end

endmodule

// File: tb/tb_preg_decode_execute.sv
// Self-checking bench for the ID/EX pipeline register.
module tb_preg_decode_execute;
    import core_pkg::*;

    logic                  clk;
    logic                  arst;
    logic                  stall;
    logic                  flush;
    logic                  valid_in;
    t_ex_ctrl              ctrl_in;
    t_ex_data              data_in;
    t_ex_ctrl              ctrl_out;
    t_ex_data              data_out;
    logic                  valid_out;
    logic [REG_ADDR_W-1:0] load_rd;
    logic [31:0]           bubble_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state, described in terms of what execute should observe.
    t_ex_ctrl    exp_ctrl;
    t_ex_data    exp_data;
    logic        exp_valid;
    logic [31:0] exp_cnt;

    preg_decode_execute #(.CNT_WIDTH(32)) dut (
        .i_clk        (clk),
        .i_arst       (arst),
        .i_stall_exec (stall),
        .i_flush_exec (flush),
        .i_valid      (valid_in),
        .i_ctrl       (ctrl_in),
        .i_data       (data_in),
        .o_ctrl       (ctrl_out),
        .o_data       (data_out),
        .o_valid      (valid_out),
        .o_load_rd    (load_rd),
        .o_bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REG_ADDR_W-1:0] exp_load_rd();
        if (exp_valid && exp_ctrl.load_instr && exp_data.rd_addr != 0)
            return exp_data.rd_addr;
        return '0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".ctrl"},  512'(ctrl_out),   512'(exp_ctrl));
        chk({tag, ".data"},  512'(data_out),   512'(exp_data));
        chk({tag, ".valid"}, 512'(valid_out),  512'(exp_valid));
        chk({tag, ".ldrd"},  512'(load_rd),    512'(exp_load_rd()));
        chk({tag, ".cnt"},   512'(bubble_cnt), 512'(exp_cnt));
    endtask

    function automatic t_ex_ctrl rand_ctrl();
        logic [31:0] r;
        r = $urandom;
        return r[$bits(t_ex_ctrl)-1:0];
    endfunction

    function automatic t_ex_data rand_data();
        logic [383:0] big;
        for (int k = 0; k < 12; k++) big[k*32 +: 32] = $urandom;
        return big[$bits(t_ex_data)-1:0];
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // One clock edge: drive inputs at the falling edge, advance the model,
    // then compare just after the rising edge.
    task automatic step(input string tag, input logic s, input logic f,
                        input logic v, input t_ex_ctrl c, input t_ex_data d);
        @(negedge clk);
        stall = s; flush = f; valid_in = v; ctrl_in = c; data_in = d;
        if (f) begin
            exp_ctrl = '0; exp_data = '0; exp_valid = 1'b0;
            exp_cnt = sat_inc(exp_cnt);
        end else if (!s) begin
            exp_data  = d;
            exp_valid = v;
            exp_ctrl  = v ? c : '0;
            if (!v) exp_cnt = sat_inc(exp_cnt);
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        exp_ctrl = '0; exp_data = '0; exp_valid = 1'b0; exp_cnt = '0;
    endtask

    initial begin : main
        t_ex_ctrl c;
        t_ex_data d;
        logic [31:0] r;

        arst = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b1;
        ctrl_in = rand_ctrl(); data_in = rand_data();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        arst = 1'b0;

        // Normal load of a load instruction with rd=7.
        c = '0; c.load_instr = 1'b1; c.reg_we = 1'b1; c.result_src = 3'b001;
        d = rand_data(); d.rd_addr = 5'd7;
        step("load_rd7", 1'b0, 1'b0, 1'b1, c, d);
        chk("load_rd7.tap", 512'(load_rd), 512'(5'd7));
        d.rd_addr = 5'd0;
        step("load_rd0", 1'b0, 1'b0, 1'b1, c, d);
        chk("load_rd0.tap", 512'(load_rd), 512'(5'd0));

        // Bubble first so the counter is non-zero before the async reset.
        step("pre_bubble", 1'b0, 1'b1, 1'b1, rand_ctrl(), rand_data());
        c = '0; c.reg_we = 1'b1; d = rand_data(); d.rd_addr = 5'd5;
        step("add_rd5", 1'b0, 1'b0, 1'b1, c, d);
        @(negedge clk);
        #2;
        arst = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        arst = 1'b0;

        // Stall for three edges while the inputs keep changing.
        c = rand_ctrl(); d = rand_data();
        step("pre_stall", 1'b0, 1'b0, 1'b1, c, d);
        step("pre_stall_bubble", 1'b0, 1'b0, 1'b0, rand_ctrl(), rand_data());
        step("pre_stall_load", 1'b0, 1'b0, 1'b1, rand_ctrl(), rand_data());
        for (int i = 0; i < 3; i++)
            step($sformatf("stall%0d", i), 1'b1, 1'b0, i[0], rand_ctrl(), rand_data());

        // Flush wins over stall while holding a store.
        c = rand_ctrl(); c.mem_we = 1'b1;
        step("store", 1'b0, 1'b0, 1'b1, c, rand_data());
        step("flush_stall", 1'b1, 1'b1, 1'b1, rand_ctrl(), rand_data());

        // Invalid slot carrying side-effecting controls.
        c = rand_ctrl(); c.mem_we = 1'b1; c.jump = 1'b1;
        step("invalid_slot", 1'b0, 1'b0, 1'b0, c, rand_data());

        // Randomized mix of stall, flush and valid patterns.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            step($sformatf("rand%0d", i), r < 20, (r % 7) == 0,
                 $urandom_range(0, 9) < 7, rand_ctrl(), rand_data());
        end

        // Saturation: preload the counter near its ceiling.
        @(negedge clk);
        stall = 1'b1; flush = 1'b0;
        #1;
        force dut.bubble_cnt_reg = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_cnt_reg;
        exp_cnt = 32'hFFFF_FFFE;
        #1;
        chk("sat_preload", 512'(bubble_cnt), 512'(exp_cnt));
        for (int i = 0; i < 3; i++)
            step($sformatf("sat_flush%0d", i), 1'b0, 1'b1, 1'b1, rand_ctrl(), rand_data());
        chk("sat_final", 512'(bubble_cnt), 512'(32'hFFFF_FFFF));
        step("sat_invalid", 1'b0, 1'b0, 1'b0, rand_ctrl(), rand_data());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
